// File: rtl/sbc32_serial.sv
// sbc32_serial: serial subtract-with-borrow unit.
// Computes D = A - B - Bin one SLICE-bit slice per clock, LSB slice first,
// rippling the borrow between slices. Start/busy/done handshake; reports
// unsigned borrow, zero, negative and signed overflow on completion.
module sbc32_serial #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] d_next_s;
    logic             borrow_r;
    logic [CW-1:0]    cnt_r;
    logic [31:0]      base_s;
    logic [SLICE:0]   diff_s;
    logic             last_s;
    logic             busy_r;
    logic             done_r;
    logic             bout_r;
    logic             zero_r;
    logic             neg_r;
    logic             ovf_r;
    logic             busy_next_s;
    logic             done_next_s;

    assign busy = busy_r;
    assign done = done_r;
    assign D    = d_r;
    assign Bout = bout_r;
    assign zero = zero_r;
    assign neg  = neg_r;
    assign ovf  = ovf_r;

    // Slice arithmetic: subtract the current slice with the rippled borrow.
    always_comb begin
        base_s   = 32'(cnt_r) * 32'(SLICE);
        diff_s   = {1'b0, a_r[base_s +: SLICE]} - {1'b0, b_r[base_s +: SLICE]}
                   - {{SLICE{1'b0}}, borrow_r};
        d_next_s = d_r;
        d_next_s[base_s +: SLICE] = diff_s[SLICE-1:0];
        last_s   = (cnt_r == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: IDLE accepts start, RUN exits after the last slice.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode: next values of the registered busy/done handshake.
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_r)
            RUN: begin
                busy_next_s = ~last_s;
                done_next_s = last_s;
            end
            default: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
        endcase
    end

    // Operand capture, slice writeback, borrow ripple and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            d_r      <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            bout_r   <= 1'b0;
            zero_r   <= 1'b0;
            neg_r    <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            done_r <= done_next_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r      <= A;
                        b_r      <= B;
                        borrow_r <= Bin;
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    d_r      <= d_next_s;
                    borrow_r <= diff_s[SLICE];
                    if (last_s) begin
                        cnt_r  <= {CW{1'b0}};
                        bout_r <= diff_s[SLICE];
                        zero_r <= (d_next_s == {WIDTH{1'b0}});
                        neg_r  <= d_next_s[WIDTH-1];
                        ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                                  (d_next_s[WIDTH-1] != a_r[WIDTH-1]);
                    end else begin
                        cnt_r <= cnt_r + CW'(1'b1);
                        // Flags from the previous result drop on the first slice edge.
                        if (cnt_r == {CW{1'b0}}) begin
                            bout_r <= 1'b0;
                            zero_r <= 1'b0;
                            neg_r  <= 1'b0;
                            ovf_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule
